// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and tap indexing for the 5x5 window generator.
package conv_pkg;
  localparam int unsigned KERNEL   = 5;
  localparam int unsigned NUM_TAPS = KERNEL * KERNEL;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_W    = NUM_TAPS * PIX_W;

  typedef enum logic [0:0] {S_FILL, S_RUN} state_e;

  // r=0 is the oldest row, c=0 the oldest column
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
    return KERNEL * r + c;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// One image line of storage: combinational read and registered write at the same address,
// so a single accepted pixel reads the previous line's value before overwriting it.
module conv_line_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/conv_5x5_window_gen.sv
// Raster-stream to 5x5 window generator: four chained line buffers feed a 5x5 shift array
// whose contents are registered into a single output slot for each valid window position.
module conv_5x5_window_gen #(
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned IMG_HEIGHT = 16,
  parameter int unsigned PIX_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_sof,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [25*PIX_W-1:0]  win_data,
  output logic [15:0]          win_x,
  output logic [15:0]          win_y,
  output logic                 frame_done
);
  import conv_pkg::*;

  localparam int unsigned LB_AW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] Y_FILL = 16'(KERNEL - 2);

  state_e                r_state;
  logic [15:0]           r_x, r_y;
  logic                  r_win_valid, r_frame_done;
  logic [25*PIX_W-1:0]   r_win_data;
  logic [15:0]           r_win_x, r_win_y;
  logic [PIX_W-1:0]      r_win [KERNEL][KERNEL];

  logic                  w_accept, w_emit, w_row_end, w_frame_end;
  logic [15:0]           w_x, w_y;
  logic [PIX_W-1:0]      w_lb_wr [KERNEL-1];
  logic [PIX_W-1:0]      w_lb_rd [KERNEL-1];
  logic [PIX_W-1:0]      w_col [KERNEL];
  logic [PIX_W-1:0]      w_next [KERNEL][KERNEL];
  logic [25*PIX_W-1:0]   w_packed;

  assign pix_ready   = rst_n && (!r_win_valid || win_ready);
  assign w_accept    = pix_valid && pix_ready;
  // An accepted start-of-frame pixel is position (0,0) regardless of the counters
  assign w_x         = pix_sof ? '0 : r_x;
  assign w_y         = pix_sof ? '0 : r_y;
  assign w_row_end   = (w_x == X_LAST);
  assign w_frame_end = w_row_end && (w_y == Y_LAST);
  assign w_emit      = w_accept && !pix_sof && (r_state == S_RUN) && (r_x >= 16'(KERNEL - 1));

  for (genvar i = 0; i < KERNEL - 1; i++) begin : g_lb
    conv_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIX_W),
      .AW    (LB_AW)
    ) u_lb (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (w_x[LB_AW-1:0]),
      .i_wdata (w_lb_wr[i]),
      .o_rdata (w_lb_rd[i])
    );
  end

  always_comb begin
    w_lb_wr[0] = pix_data;
    for (int i = 1; i < KERNEL - 1; i++) w_lb_wr[i] = w_lb_rd[i-1];
    w_col[KERNEL-1] = pix_data;
    for (int r = 0; r < KERNEL - 1; r++) w_col[r] = w_lb_rd[KERNEL-2-r];
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) w_next[r][c] = r_win[r][c+1];
      w_next[r][KERNEL-1] = w_col[r];
    end
    w_packed = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) w_packed[tap_idx(r, c)*PIX_W +: PIX_W] = w_next[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_x          <= '0;
      r_y          <= '0;
      r_win_valid  <= 1'b0;
      r_win_data   <= '0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_frame_end;
      if (w_accept) begin
        r_win <= w_next;
        r_x   <= w_row_end ? '0 : w_x + 16'd1;
        if (w_row_end) r_y <= (w_y == Y_LAST) ? '0 : w_y + 16'd1;
        else           r_y <= w_y;
        if (w_frame_end)                     r_state <= S_FILL;
        else if (w_row_end && w_y == Y_FILL) r_state <= S_RUN;
        else if (pix_sof)                    r_state <= S_FILL;
      end
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_packed;
        r_win_x     <= w_x;
        r_win_y     <= w_y;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign win_data   = r_win_data;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
  assign frame_done = r_frame_done;
endmodule
